// File: rtl/dsram_pkg.sv
// Shared types and helpers for the per-way L1 data array with line fill.
package dsram_pkg;

  localparam int DEF_ADDR_WIDTH = 13;
  localparam int LINE_BITS = 256;
  localparam int BEAT_BITS = 64;
  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_st_e;

  function automatic logic [7:0] merge_byte(
    input logic [7:0] old_b,
    input logic [7:0] new_b,
    input logic       be
  );
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/dsram_core.sv
// Behavioural line array: one byte-enabled write port, one registered read.
module dsram_core
  import dsram_pkg::*;
#(
  parameter int AW = 13,
  parameter int NB = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [NB-1:0]   wbe,
  input  logic [8*NB-1:0] wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [8*NB-1:0] rdata
);

  logic [8*NB-1:0] mem_q [2**AW];
  logic [8*NB-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        mem_q[waddr][8*i+:8] <=
          merge_byte(mem_q[waddr][8*i+:8],
                     wdata[8*i+:8], wbe[i]);
      end
    end
  end

  // Read sees the pre-write line; the top patches same-cycle writes.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dsram_fill.sv
// Per-way data array: byte-enabled CPU writes, multi-beat line fill,
// same-cycle read bypass and 1- or 2-cycle read latency.
module dsram_fill
  import dsram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_BYTES = LINE_BITS / 8,
  parameter int BEAT_BYTES = BEAT_BITS / 8,
  parameter int RD_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [8*LINE_BYTES-1:0] rd_data,
  output logic                    rd_valid,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [LINE_BYTES-1:0]   wr_be,
  input  logic [8*LINE_BYTES-1:0] wr_data,
  input  logic                    fill_start,
  input  logic [ADDR_WIDTH-1:0]   fill_addr,
  input  logic                    fill_valid,
  input  logic [8*BEAT_BYTES-1:0] fill_data,
  output logic                    fill_ready,
  output logic                    fill_busy,
  output logic                    fill_done
);

  localparam int L_BITS  = 8 * LINE_BYTES;
  localparam int N_BEATS = LINE_BYTES / BEAT_BYTES;
  localparam int C_W     = $clog2(N_BEATS);

  fill_st_e              state_q, state_d;
  logic [C_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
  logic [LINE_BYTES-1:0] byp_be_q, byp_be_d;
  logic [L_BITS-1:0]     byp_data_q, byp_data_d;
  logic                  v1_q, v1_d;

  logic                  beat_acc;
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [LINE_BYTES-1:0] w_be, beat_mask;
  logic [L_BITS-1:0]     w_data, core_rd, merged;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    faddr_d    = faddr_q;
    fill_ready = 1'b0;
    beat_acc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fill_start) begin
          state_d = FILL;
          faddr_d = fill_addr;
          cnt_d   = '0;
        end
      end
      FILL: begin
        fill_ready = ~wr_en;
        beat_acc   = fill_valid & ~wr_en;
        if (beat_acc) begin
          cnt_d = cnt_q + C_W'(1);
          if (cnt_q == C_W'(N_BEATS - 1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign fill_busy = (state_q != IDLE);
  assign fill_done = (state_q == DONE);

  // CPU write wins the single port; a stalled beat retries next cycle.
  always_comb begin
    beat_mask = '0;
    beat_mask[cnt_q*BEAT_BYTES +: BEAT_BYTES] = '1;
    w_en   = wr_en | beat_acc;
    w_addr = wr_en ? wr_addr : faddr_q;
    w_be   = wr_en ? wr_be : beat_mask;
    w_data = wr_en ? wr_data : {N_BEATS{fill_data}};
  end

  always_comb begin
    v1_d       = rd_en;
    byp_be_d   = byp_be_q;
    byp_data_d = byp_data_q;
    if (rd_en) begin
      byp_be_d   = (w_en && w_addr == rd_addr) ? w_be : '0;
      byp_data_d = w_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      faddr_q    <= '0;
      byp_be_q   <= '0;
      byp_data_q <= '0;
      v1_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      faddr_q    <= faddr_d;
      byp_be_q   <= byp_be_d;
      byp_data_q <= byp_data_d;
      v1_q       <= v1_d;
    end
  end

  dsram_core #(
    .AW (ADDR_WIDTH),
    .NB (LINE_BYTES)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .we    (w_en),
    .waddr (w_addr),
    .wbe   (w_be),
    .wdata (w_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (core_rd)
  );

  always_comb begin
    merged = '0;
    for (int i = 0; i < LINE_BYTES; i++) begin
      merged[8*i+:8] = merge_byte(core_rd[8*i+:8],
                                  byp_data_q[8*i+:8],
                                  byp_be_q[i]);
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [L_BITS-1:0] rd2_q, rd2_d;
    logic              v2_q, v2_d;

    always_comb begin
      v2_d  = v1_q;
      rd2_d = v1_q ? merged : rd2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd2_q <= '0;
        v2_q  <= 1'b0;
      end else begin
        rd2_q <= rd2_d;
        v2_q  <= v2_d;
      end
    end

    assign rd_data  = rd2_q;
    assign rd_valid = v2_q;
  end else begin : g_lat1
    assign rd_data  = merged;
    assign rd_valid = v1_q;
  end

endmodule

// File: tb/tb_dsram_fill.sv
// Directed bench for dsram_fill: RD_LAT=1 and RD_LAT=2 instances side by
// side against a line-level reference model of the array and fill sequence.
module tb_dsram_fill;
  import dsram_pkg::*;

  localparam int AW = 13;
  localparam int NBEATS = BEATS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic         wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]  wr_be = '0;
  logic [255:0] wr_data = '0;
  logic         fill_start = 1'b0;
  logic [AW-1:0] fill_addr = '0;
  logic         fill_valid = 1'b0;
  logic [63:0]  fill_data = '0;

  logic [255:0] rd_data1, rd_data2;
  logic rd_valid1, rd_valid2;
  logic rdy1, rdy2, busy1, busy2, done1, done2;

  always #5 clk = ~clk;

  dsram_fill #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_be(wr_be), .wr_data(wr_data),
    .fill_start(fill_start), .fill_addr(fill_addr),
    .fill_valid(fill_valid), .fill_data(fill_data),
    .fill_ready(rdy1), .fill_busy(busy1),
    .fill_done(done1)
  );

  dsram_fill #(.RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data2), .rd_valid(rd_valid2),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_be(wr_be), .wr_data(wr_data),
    .fill_start(fill_start), .fill_addr(fill_addr),
    .fill_valid(fill_valid), .fill_data(fill_data),
    .fill_ready(rdy2), .fill_busy(busy2),
    .fill_done(done2)
  );

  int n_chk = 0;
  int n_fail = 0;
  int done_pulses = 0;

  task automatic check(input string name,
                       input logic [255:0] act,
                       input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: line contents plus a known-byte mask per index.
  logic [255:0] mem [int];
  logic [31:0]  kmask [int];
  bit           filling = 0, done_ph = 0;
  int           beat = 0;
  int           faddr = 0;
  bit           e1_v = 0, e2_v = 0, e1_k = 1, e2_k = 1;
  logic [255:0] e1_d = '0, e2_d = '0;

  bit           m_acc, m_w;
  int           m_a;
  logic [31:0]  m_b, m_ok;
  logic [255:0] m_d, m_line;

  function automatic logic [255:0] apply(input logic [255:0] old,
                                         input logic [31:0] be,
                                         input logic [255:0] d);
    logic [255:0] r;
    r = old;
    for (int i = 0; i < 32; i++)
      if (be[i]) r[8*i+:8] = d[8*i+:8];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      filling = 0; done_ph = 0; beat = 0;
      e1_v = 0; e2_v = 0; e1_k = 1; e2_k = 1;
      e1_d = '0; e2_d = '0;
    end else begin
      m_acc = filling && fill_valid && !wr_en;
      m_w   = wr_en || m_acc;
      m_a   = wr_en ? int'(wr_addr) : faddr;
      m_b   = wr_en ? wr_be : (32'hFF << (beat * 8));
      m_d   = wr_en ? wr_data : {4{fill_data}};
      e2_v = e1_v;
      if (e1_v) begin e2_d = e1_d; e2_k = e1_k; end
      e1_v = rd_en;
      if (rd_en) begin
        m_line = mem.exists(int'(rd_addr)) ? mem[int'(rd_addr)] : '0;
        m_ok = kmask.exists(int'(rd_addr)) ? kmask[int'(rd_addr)] : '0;
        if (m_w && m_a == int'(rd_addr)) begin
          m_line = apply(m_line, m_b, m_d);
          m_ok = m_ok | m_b;
        end
        e1_d = m_line;
        e1_k = &m_ok;
      end
      if (m_w) begin
        if (!mem.exists(m_a)) begin mem[m_a] = '0; kmask[m_a] = '0; end
        mem[m_a] = apply(mem[m_a], m_b, m_d);
        kmask[m_a] = kmask[m_a] | m_b;
      end
      if (done_ph) done_ph = 0;
      else if (filling) begin
        if (m_acc) begin
          beat++;
          if (beat == NBEATS) begin filling = 0; done_ph = 1; end
        end
      end else if (fill_start) begin
        filling = 1; faddr = int'(fill_addr); beat = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("rd_valid1", 256'(rd_valid1), 256'(e1_v));
    check("rd_valid2", 256'(rd_valid2), 256'(e2_v));
    if (e1_k) check("rd_data1", rd_data1, e1_d);
    if (e2_k) check("rd_data2", rd_data2, e2_d);
    check("fill_ready1", 256'(rdy1), 256'(filling && !wr_en));
    check("fill_ready2", 256'(rdy2), 256'(filling && !wr_en));
    check("fill_busy1", 256'(busy1), 256'(filling || done_ph));
    check("fill_busy2", 256'(busy2), 256'(filling || done_ph));
    check("fill_done1", 256'(done1), 256'(done_ph));
    check("fill_done2", 256'(done2), 256'(done_ph));
    if (done1) done_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] be,
                    input logic [255:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_be = be; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input int a);
    rd_en = 1'b1; rd_addr = AW'(a);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic start(input int a);
    fill_start = 1'b1; fill_addr = AW'(a);
    tick();
    fill_start = 1'b0;
  endtask

  task automatic send(input logic [63:0] d);
    fill_valid = 1'b1; fill_data = d;
    tick();
    fill_valid = 1'b0;
  endtask

  logic [255:0] pat_a;

  initial begin
    pat_a = {8{32'hA5C3_0F96}};
    tick(); tick();
    check("rst_rd_valid", 256'(rd_valid1), 256'(0));
    check("rst_rd_data", rd_data1, 256'(0));
    check("rst_busy", 256'(busy1), 256'(0));
    check("rst_ready", 256'(rdy1), 256'(0));
    rst = 1'b0;
    tick();

    // full-line write then read, both latencies
    wr(5, '1, pat_a);
    rd(5);
    check("t1_lat1_data", rd_data1, pat_a);
    check("t1_lat2_notyet", 256'(rd_valid2), 256'(0));
    tick();
    check("t1_lat2_data", rd_data2, pat_a);
    check("t1_lat2_valid", 256'(rd_valid2), 256'(1));

    // partial byte write
    wr(7, '1, {32{8'h11}});
    wr(7, 32'h0000_0003, {32{8'hAA}});
    rd(7);
    check("t2_merge", rd_data1, {{30{8'h11}}, {2{8'hAA}}});

    // same-cycle read/write bypass
    wr(9, '1, {32{8'h22}});
    wr_en = 1'b1; wr_addr = 9; wr_be = 32'h1;
    wr_data = {32{8'h33}};
    rd_en = 1'b1; rd_addr = 9;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("t3_bypass1", rd_data1, {{31{8'h22}}, 8'h33});
    tick();
    check("t3_bypass2", rd_data2, {{31{8'h22}}, 8'h33});

    // fill with a gap before beat 2
    done_pulses = 0;
    start(3);
    send({8{8'h01}});
    send({8{8'h02}});
    tick();
    send({8{8'h03}});
    send({8{8'h04}});
    check("t4_done_hi", 256'(done1), 256'(1));
    tick();
    check("t4_done_lo", 256'(done1), 256'(0));
    check("t4_pulses", 256'(done_pulses), 256'(1));
    rd(3);
    check("t4_line", rd_data1,
          {{8{8'h04}}, {8{8'h03}}, {8{8'h02}}, {8{8'h01}}});

    // CPU write stalls a beat
    start(12);
    send({8{8'h05}});
    wr_en = 1'b1; wr_addr = 20; wr_be = '1;
    wr_data = {32{8'hEE}};
    fill_valid = 1'b1; fill_data = {8{8'h06}};
    @(negedge clk);
    check("t5_stall", 256'(rdy1), 256'(0));
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    check("t5_resume", 256'(rdy1), 256'(1));
    tick();
    fill_valid = 1'b0;
    send({8{8'h07}});
    send({8{8'h08}});
    tick();
    rd(12);
    check("t5_fill", rd_data1,
          {{8{8'h08}}, {8{8'h07}}, {8{8'h06}}, {8{8'h05}}});
    rd(20);
    check("t5_cpu", rd_data1, {32{8'hEE}});

    // reset mid-fill
    done_pulses = 0;
    start(4);
    send({8{8'h0A}});
    send({8{8'h0B}});
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy", 256'(busy1), 256'(0));
    check("t6_rd_data", rd_data1, 256'(0));
    tick();
    rst = 1'b0;
    tick();
    check("t6_no_done", 256'(done_pulses), 256'(0));
    start(4);
    send({8{8'h0C}});
    send({8{8'h0D}});
    send({8{8'h0E}});
    send({8{8'h0F}});
    check("t6_done", 256'(done1), 256'(1));
    tick();
    rd(4);
    check("t6_line", rd_data1,
          {{8{8'h0F}}, {8{8'h0E}}, {8{8'h0D}}, {8{8'h0C}}});
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
